// File: rtl/cic_integrator_decim.sv
// -----------------------------------------------------------------------------
// cic_integrator_decim
//
// Integrator half of a PDM-to-PCM CIC decimator. Each valid 1-bit PDM sample
// is mapped to +1/-1 and pushed through NUM_STAGES cascaded integrators that
// run at the input rate. A decimation counter picks every Rth input step
// (R = cfg_decim_i + 1). On that step the output register captures the new
// last-stage integrator value, and a one-cycle strobe is raised. The strobe
// feeds the enable of the downstream comb chain.
//
// All arithmetic is modulo 2**WIDTH and wraps silently. The comb section
// cancels the wrap as long as WIDTH >= 1 + NUM_STAGES*ceil(log2(R)).
//
// Parameters
//   NUM_STAGES  number of integrator stages (1..8)
//   WIDTH       accumulator / output width
//   DECIM_W     width of the decimation-ratio field
//
// Ports
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   en_i          block enable; 0 holds all state and suppresses strobes
//   clr_i         synchronous clear of all state, has priority over en_i
//   cfg_decim_i   decimation ratio minus one
//   data_i        PDM bit: 1 -> +1, 0 -> -1
//   data_valid_i  data_i is valid this cycle
//   data_o        decimated integrator output (two's complement)
//   data_valid_o  one-cycle strobe, data_o was updated
// -----------------------------------------------------------------------------
module cic_integrator_decim #(
  parameter int NUM_STAGES = 5,
  parameter int WIDTH      = 64,
  parameter int DECIM_W    = 10
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [DECIM_W-1:0] cfg_decim_i,
  input  logic               data_i,
  input  logic               data_valid_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               data_valid_o
);

  localparam logic [WIDTH-1:0]   ACC_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ACC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ACC_NEG1 = {WIDTH{1'b1}};
  localparam logic [DECIM_W-1:0] CNT_ZERO = {DECIM_W{1'b0}};
  localparam logic [DECIM_W-1:0] CNT_ONE  = {{(DECIM_W-1){1'b0}}, 1'b1};

  // Map a PDM bit onto the sign-extended +1 / -1 increment of the first stage.
  function automatic logic [WIDTH-1:0] pdm_step(input logic bit_val);
    logic [WIDTH-1:0] step_val;
    if (bit_val) begin
      step_val = ACC_ONE;
    end else begin
      step_val = ACC_NEG1;
    end
    return step_val;
  endfunction

  // An input step is the only event that advances integrators and counter;
  // clr_i is handled separately with higher priority in each register block.
  logic               step_s;
  logic               wrap_s;
  logic [DECIM_W-1:0] cnt_r;
  logic [DECIM_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]   integ_r     [NUM_STAGES];
  logic [WIDTH-1:0]   integ_nxt_s [NUM_STAGES];
  logic [WIDTH-1:0]   data_r;
  logic               valid_r;

  assign step_s = en_i & data_valid_i;

  // Next-value datapath: every stage reads only pre-edge values, so all
  // stages update in parallel (stage k adds the OLD value of stage k-1).
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      integ_nxt_s[k] = integ_r[k];
    end
    integ_nxt_s[0] = integ_r[0] + pdm_step(data_i);
    for (int k = 1; k < NUM_STAGES; k++) begin
      integ_nxt_s[k] = integ_r[k] + integ_r[k-1];
    end
  end

  // Decimation counter next state. The >= compare makes the counter wrap on
  // the next step if the ratio is lowered below the current count.
  always_comb begin
    wrap_s    = 1'b0;
    cnt_nxt_s = cnt_r;
    if (cnt_r >= cfg_decim_i) begin
      wrap_s    = 1'b1;
      cnt_nxt_s = CNT_ZERO;
    end else begin
      wrap_s    = 1'b0;
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Integrator bank: clear, advance on an input step, otherwise hold.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ_r[k] <= ACC_ZERO;
      end
    end else if (clr_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ_r[k] <= ACC_ZERO;
      end
    end else if (step_s) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ_r[k] <= integ_nxt_s[k];
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        integ_r[k] <= integ_r[k];
      end
    end
  end

  // Decimation counter: counts input steps only; the pending count survives
  // en_i=0 periods.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r <= CNT_ZERO;
    end else if (clr_i) begin
      cnt_r <= CNT_ZERO;
    end else if (step_s) begin
      cnt_r <= cnt_nxt_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output register and strobe: capture the new last-stage value on the
  // decimating step; the strobe drops on every other cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_r  <= ACC_ZERO;
      valid_r <= 1'b0;
    end else if (clr_i) begin
      data_r  <= ACC_ZERO;
      valid_r <= 1'b0;
    end else if (step_s && wrap_s) begin
      data_r  <= integ_nxt_s[NUM_STAGES-1];
      valid_r <= 1'b1;
    end else begin
      data_r  <= data_r;
      valid_r <= 1'b0;
    end
  end

  assign data_o       = data_r;
  assign data_valid_o = valid_r;

endmodule

// File: tb/tb_cic_integrator_decim.sv
// -----------------------------------------------------------------------------
// tb_cic_integrator_decim
//
// Directed bench. Four instances share one stimulus bus:
//   u_n1 : N=1, WIDTH=64    u_n2 : N=2, WIDTH=64
//   u_w8 : N=1, WIDTH=8     u_n5 : N=5, WIDTH=64 (defaults)
// Each scenario clears the block first and checks the relevant instance.
// With all-ones input, stage k after t steps holds C(t, k+1), so the
// N=5 output after 8 steps is C(8,5) = 56.
// -----------------------------------------------------------------------------
module tb_cic_integrator_decim;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        clr;
  logic [9:0]  cfg;
  logic        din;
  logic        dvalid;

  logic [63:0] d_n1, d_n2, d_n5;
  logic [7:0]  d_w8;
  logic        v_n1, v_n2, v_n5, v_w8;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int str_n1    = 0;
  int str_n2    = 0;
  int str_n5    = 0;
  int str_w8    = 0;

  always #5 clk = ~clk;

  cic_integrator_decim #(.NUM_STAGES(1), .WIDTH(64), .DECIM_W(10)) u_n1 (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .clr_i(clr), .cfg_decim_i(cfg),
    .data_i(din), .data_valid_i(dvalid), .data_o(d_n1), .data_valid_o(v_n1));

  cic_integrator_decim #(.NUM_STAGES(2), .WIDTH(64), .DECIM_W(10)) u_n2 (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .clr_i(clr), .cfg_decim_i(cfg),
    .data_i(din), .data_valid_i(dvalid), .data_o(d_n2), .data_valid_o(v_n2));

  cic_integrator_decim #(.NUM_STAGES(1), .WIDTH(8), .DECIM_W(10)) u_w8 (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .clr_i(clr), .cfg_decim_i(cfg),
    .data_i(din), .data_valid_i(dvalid), .data_o(d_w8), .data_valid_o(v_w8));

  cic_integrator_decim #(.NUM_STAGES(5), .WIDTH(64), .DECIM_W(10)) u_n5 (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .clr_i(clr), .cfg_decim_i(cfg),
    .data_i(din), .data_valid_i(dvalid), .data_o(d_n5), .data_valid_o(v_n5));

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (v_n1) str_n1++;
    if (v_n2) str_n2++;
    if (v_n5) str_n5++;
    if (v_w8) str_w8++;
  endtask

  task automatic clear_strobes();
    str_n1 = 0; str_n2 = 0; str_n5 = 0; str_w8 = 0;
  endtask

  task automatic step(input logic bit_val);
    en     = 1'b1;
    dvalid = 1'b1;
    din    = bit_val;
    tick();
    dvalid = 1'b0;
  endtask

  task automatic idle();
    en     = 1'b1;
    dvalid = 1'b0;
    tick();
  endtask

  // Clear pulse with en_i low, which also exercises clr_i priority.
  task automatic pulse_clr();
    en  = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    en  = 1'b1;
    clear_strobes();
  endtask

  logic [63:0] tri_tbl [5];

  initial begin
    tri_tbl[0] = 64'd0; tri_tbl[1] = 64'd1; tri_tbl[2] = 64'd3;
    tri_tbl[3] = 64'd6; tri_tbl[4] = 64'd10;

    rstn = 1'b0; en = 1'b0; clr = 1'b0; cfg = 10'd0; din = 1'b0; dvalid = 1'b0;
    tick();
    tick();
    check_val("reset_data_n5", d_n5, 64'd0);
    check_val("reset_valid_n5", {63'd0, v_n5}, 64'd0);
    check_val("reset_data_n1", d_n1, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: N=1, R=4, all ones -> 4, 8, 12
    cfg = 10'd3;
    pulse_clr();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      if ((i % 4) == 0) begin
        check_val("t1_valid", {63'd0, v_n1}, 64'd1);
        check_val("t1_data", d_n1, 64'(i));
      end else begin
        check_val("t1_novalid", {63'd0, v_n1}, 64'd0);
      end
    end
    idle();
    check_val("t1_valid_drop", {63'd0, v_n1}, 64'd0);
    check_val("t1_hold", d_n1, 64'd12);
    check_val("t1_strobes", 64'(str_n1), 64'd3);

    // 2: N=1, R=4, all zeros -> -4, -8
    pulse_clr();
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      if (i == 4) check_val("t2_m4", d_n1, 64'hFFFF_FFFF_FFFF_FFFC);
      if (i == 8) check_val("t2_m8", d_n1, 64'hFFFF_FFFF_FFFF_FFF8);
    end

    // 3: N=2, R=1 -> 0,1,3,6,10 with one strobe per step
    cfg = 10'd0;
    pulse_clr();
    for (int t = 0; t < 5; t++) begin
      step(1'b1);
      check_val("t3_data", d_n2, tri_tbl[t]);
      check_val("t3_valid", {63'd0, v_n2}, 64'd1);
    end

    // 4: WIDTH=8 wraps 0x7F -> 0x80 silently
    pulse_clr();
    for (int i = 1; i <= 128; i++) begin
      step(1'b1);
      if (i == 127) check_val("t4_7f", {56'd0, d_w8}, 64'h7F);
      if (i == 128) check_val("t4_80", {56'd0, d_w8}, 64'h80);
    end
    check_val("t4_strobes", 64'(str_w8), 64'd128);
    check_val("t4_n1_128", d_n1, 64'd128);

    // 5a: N=5, R=8, clr mid-count
    cfg = 10'd7;
    pulse_clr();
    for (int i = 1; i <= 8; i++) step(1'b1);
    check_val("t5_first", d_n5, 64'd56);
    for (int i = 1; i <= 5; i++) step(1'b1);
    pulse_clr();
    check_val("t5_clr_data", d_n5, 64'd0);
    check_val("t5_clr_valid", {63'd0, v_n5}, 64'd0);
    for (int i = 1; i <= 7; i++) step(1'b1);
    check_val("t5_no_early", 64'(str_n5), 64'd0);
    step(1'b1);
    check_val("t5_valid_8", {63'd0, v_n5}, 64'd1);
    check_val("t5_data_8", d_n5, 64'd56);

    // 5b: same with asynchronous reset between edges
    for (int i = 1; i <= 5; i++) step(1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_val("t5_rst_async", d_n5, 64'd56 - 64'd56);
    @(negedge clk);
    rstn = 1'b1;
    clear_strobes();
    for (int i = 1; i <= 7; i++) step(1'b1);
    check_val("t5_rst_no_early", 64'(str_n5), 64'd0);
    step(1'b1);
    check_val("t5_rst_data_8", d_n5, 64'd56);
    check_val("t5_rst_valid_8", {63'd0, v_n5}, 64'd1);

    // 5c: lowering the ratio below the count forces a wrap on the next step
    pulse_clr();
    for (int i = 1; i <= 5; i++) step(1'b1);
    cfg = 10'd2;
    step(1'b1);
    check_val("t5c_wrap_valid", {63'd0, v_n1}, 64'd1);
    check_val("t5c_wrap_data", d_n1, 64'd6);
    step(1'b1);
    step(1'b1);
    check_val("t5c_mid", {63'd0, v_n1}, 64'd0);
    step(1'b1);
    check_val("t5c_next", d_n1, 64'd9);

    // 6: N=2, R=2 with gaps -> 1, 6, 15 as gap-free
    cfg = 10'd1;
    pulse_clr();
    step(1'b1);
    idle();
    step(1'b1);
    check_val("t6_s2", d_n2, 64'd1);
    idle();
    check_val("t6_drop", {63'd0, v_n2}, 64'd0);
    step(1'b1);
    en = 1'b0; dvalid = 1'b1; din = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_val("t6_en_strobes", 64'(str_n2), 64'd1);
    check_val("t6_en_hold", d_n2, 64'd1);
    step(1'b1);
    check_val("t6_s4", d_n2, 64'd6);
    en = 1'b0;
    tick();
    check_val("t6_en_drop", {63'd0, v_n2}, 64'd0);
    idle();
    step(1'b1);
    idle();
    step(1'b1);
    check_val("t6_s6", d_n2, 64'd15);
    check_val("t6_strobes", 64'(str_n2), 64'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
